// File: rtl/i8080_input_pkg.sv
// Host-link definitions shared by the i8080 input and output blocks.
package i8080_input_pkg;

    // Opcode bytes that open a host-link frame.
    localparam logic [7:0] OPCODE_OUT = 8'h03;
    localparam logic [7:0] OPCODE_IN  = 8'h04;

    // Frame parser: idle until an opcode arrives, then expect one payload byte.
    typedef enum logic {
        WAIT_OP   = 1'b0,
        WAIT_DATA = 1'b1
    } parse_state_t;

endpackage

// File: rtl/i8080_input_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with registered occupancy count.
module byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on an empty FIFO is ignored; a push while full only fits if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is shown directly; the bus reads zero while nothing is stored.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and count bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is left uninitialised; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i8080_input.sv
// Host-to-CPU input path: parses opcode/payload frames from the UART and
// queues payload bytes for the CPU IN port.
module i8080_input #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] OPCODE_IN = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    input  logic       rd,
    output logic [7:0] data,
    output logic       avail,
    output logic       overflow,
    input  logic       ovf_clr
);

    import i8080_input_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    parse_state_t      state;
    parse_state_t      state_nxt;
    logic              payload_push;
    logic              rd_pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (payload_push),
        .push_data (uart_data),
        .pop       (rd),
        .pop_data  (data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign avail  = !fifo_empty;
    assign rd_pop = rd && (fifo_count != '0);
    // A payload is lost only when the FIFO is full and no read frees a slot this cycle.
    assign drop   = payload_push && fifo_full && !rd_pop;

    // Parser state register; reset abandons any half-received frame.
    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_OP;
        else
            state <= state_nxt;
    end

    // Parser next state and payload push decision; idle cycles hold the state.
    always_comb begin
        state_nxt    = state;
        payload_push = 1'b0;
        case (state)
            WAIT_OP: begin
                if (uart_valid && uart_data == OPCODE_IN)
                    state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (uart_valid) begin
                    payload_push = 1'b1;
                    state_nxt    = WAIT_OP;
                end
            end
            default: state_nxt = WAIT_OP;
        endcase
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_i8080_input.sv
// Directed bench for i8080_input (DEPTH=4, OPCODE_IN=04).
module tb_i8080_input;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       rd;
    logic [7:0] data;
    logic       avail;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    i8080_input #(
        .DEPTH     (4),
        .OPCODE_IN (8'h04)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .rd         (rd),
        .data       (data),
        .avail      (avail),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One UART byte, optionally with rd and/or ovf_clr in the same cycle.
    task automatic send(input logic [7:0] b, input logic with_rd, input logic with_clr);
        uart_valid = 1'b1;
        uart_data  = b;
        rd         = with_rd;
        ovf_clr    = with_clr;
        @(negedge clk);
        uart_valid = 1'b0;
        rd         = 1'b0;
        ovf_clr    = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b);
        send(8'h04, 1'b0, 1'b0);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    function automatic logic [7:0] cnt();
        return 8'(u_dut.u_fifo.count);
    endfunction

    initial begin
        rst        = 1'b1;
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        rd         = 1'b0;
        ovf_clr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_avail", 8'(avail), 8'h00);
        check("rst_data", data, 8'h00);
        check("rst_ovf", 8'(overflow), 8'h00);
        check("rst_count", cnt(), 8'h00);

        // Basic frame and pop
        frame(8'h5A);
        check("f1_avail", 8'(avail), 8'h01);
        check("f1_data", data, 8'h5A);
        pop();
        check("f1_pop_avail", 8'(avail), 8'h00);
        check("f1_pop_data", data, 8'h00);

        // Non-opcode bytes discarded; opcode as payload
        send(8'h11, 1'b0, 1'b0);
        send(8'h5A, 1'b0, 1'b0);
        check("disc_count0", cnt(), 8'h00);
        send(8'h04, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        check("disc_count", cnt(), 8'h01);
        check("disc_data", data, 8'h04);
        pop();
        check("disc_empty", 8'(avail), 8'h00);

        // Overflow: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) frame(8'(i));
        check("ovf_count", cnt(), 8'h04);
        check("ovf_flag", 8'(overflow), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_rd%0d", i), data, 8'(i));
            pop();
        end
        check("ovf_drained", 8'(avail), 8'h00);
        check("ovf_still", 8'(overflow), 8'h01);
        clr();
        check("ovf_clr", 8'(overflow), 8'h00);

        // Clear in the same cycle as a new drop: flag stays set
        for (int i = 1; i <= 4; i++) frame(8'(i));
        send(8'h04, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b1);
        check("clr_vs_drop", 8'(overflow), 8'h01);
        clr();
        check("clr_again", 8'(overflow), 8'h00);
        check("full_count", cnt(), 8'h04);

        // Push and pop together while full: both accepted, no overflow
        send(8'h04, 1'b0, 1'b0);
        send(8'h09, 1'b1, 1'b0);
        check("pp_full_count", cnt(), 8'h04);
        check("pp_full_ovf", 8'(overflow), 8'h00);
        check("pp_rd0", data, 8'h02); pop();
        check("pp_rd1", data, 8'h03); pop();
        check("pp_rd2", data, 8'h04); pop();
        check("pp_rd3", data, 8'h09); pop();
        check("pp_empty", 8'(avail), 8'h00);

        // Push and pop together while empty: pop ignored, count 1
        send(8'h04, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        check("pp_empty_count", cnt(), 8'h01);
        check("pp_empty_data", data, 8'hA5);
        // Push and pop together at count 1: count unchanged, head advances
        send(8'h04, 1'b0, 1'b0);
        send(8'hB6, 1'b1, 1'b0);
        check("pp_mid_count", cnt(), 8'h01);
        check("pp_mid_data", data, 8'hB6);
        pop();

        // Reset mid-frame abandons it; 77 parsed as opcode
        send(8'h04, 1'b0, 1'b0);
        rst = 1'b1;
        rd = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd = 1'b0;
        ovf_clr = 1'b0;
        send(8'h77, 1'b0, 1'b0);
        check("rst_mid_avail", 8'(avail), 8'h00);
        check("rst_mid_count", cnt(), 8'h00);
        pop();
        check("under_avail", 8'(avail), 8'h00);
        check("under_data", data, 8'h00);
        check("under_count", cnt(), 8'h00);
        frame(8'h66);
        check("after_rst_data", data, 8'h66);
        pop();

        // Wrap-around: ten frames, each read out immediately
        for (int i = 0; i < 10; i++) begin
            frame(8'(8'h20 + i));
            check($sformatf("wrap_cnt%0d", i), cnt(), 8'h01);
            check($sformatf("wrap_dat%0d", i), data, 8'(8'h20 + i));
            pop();
            check($sformatf("wrap_emp%0d", i), cnt(), 8'h00);
        end
        check("wrap_ovf", 8'(overflow), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i8080_input.md
I8080_INPUT -- requirements
Module: i8080_input

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter OPCODE_IN, default 8'h04, meaning the host-to-CPU input-data opcode byte.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port uart_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-006 SHALL have port uart_data, input, 8 bits: the received byte, qualified by uart_valid.
REQ-007 SHALL have port rd, input, 1 bit: CPU IN-port read strobe; each high cycle is one pop request.
REQ-008 SHALL have port data, output, 8 bits: FIFO head byte presented to the CPU data bus.
REQ-009 SHALL have port avail, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag for a payload byte dropped because the FIFO was full.
REQ-011 SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-012 SHALL implement a parser FSM with states WAIT_OP and WAIT_DATA.
REQ-013 In WAIT_OP, uart_valid with uart_data==OPCODE_IN SHALL move to WAIT_DATA; any other byte SHALL be discarded and the FSM SHALL stay in WAIT_OP.
REQ-014 In WAIT_DATA, the next uart_valid byte SHALL be the payload (any value, including OPCODE_IN); the FSM SHALL push it to the FIFO and return to WAIT_OP.
REQ-015 Cycles without uart_valid SHALL leave the FSM state unchanged; there is no timeout.
REQ-016 Latency: a payload byte accepted at edge N SHALL be visible on data, with avail=1, after edge N (registered count).
REQ-017 Data SHALL be first-word-fall-through: data equals the head entry while avail=1, and 8'h00 while avail=0.
REQ-018 rd with avail=1 SHALL pop exactly one entry per cycle; rd with avail=0 SHALL be ignored, with no state change and no underflow.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be $clog2(DEPTH)+1 bits.
REQ-020 A push while full without a simultaneous pop SHALL be dropped, and overflow SHALL be set on the next edge.
REQ-021 A simultaneous push and pop while full SHALL accept both; the count SHALL stay at DEPTH and overflow SHALL not be set.
REQ-022 A simultaneous push and pop while empty SHALL ignore the pop and accept the push, giving count 1.
REQ-023 A simultaneous push and pop at any other count SHALL leave the count unchanged.
REQ-024 If ovf_clr and an overflow event occur in the same cycle, overflow SHALL end set.

Reset
REQ-025 On rst high at a clock edge: FSM=WAIT_OP, pointers=0, count=0, avail=0, data=8'h00, overflow=0; FIFO storage contents need not be cleared.
REQ-026 Reset mid-frame (in WAIT_DATA) SHALL abandon the frame; the next byte is parsed as an opcode.
REQ-027 rst SHALL take priority over uart_valid, rd and ovf_clr in the same cycle.

Structure
REQ-028 A shared package SHALL hold the host-link opcode constants OPCODE_OUT=8'h03 and OPCODE_IN=8'h04, used by both this block and the output block.
REQ-029 The FIFO SHALL be a sub-module named byte_fifo (synchronous, FWFT, parameterised depth, full/empty/count outputs); the parser and overflow flag SHALL be in i8080_input.

Verification
REQ-030 Bytes 04,5A -> after the 5A edge: avail=1, data=5A; then rd for 1 cycle -> avail=0, data=00.
REQ-031 Bytes 11,5A,04,04 -> exactly one entry, 04; the 11 and 5A are discarded.
REQ-032 Five frames 04,01..04,05 with no rd (DEPTH=4) -> entries 01..04 read back in order, overflow=1; ovf_clr -> overflow=0.
REQ-033 FIFO full; payload byte 09 arrives in the same cycle as rd -> count stays 4, overflow=0, final read order 02,03,04,09.
REQ-034 Byte 04, then rst pulse, then byte 77 -> FIFO empty and avail=0 (77 is parsed as an opcode); rd while empty -> no change.
REQ-035 Wrap-around: 10 frames, each read out immediately -> all 10 payloads returned in order, count never exceeds 1.
